// File: rtl/float_comp_pkg.sv
// Shared widths, exponent bias and one-hot compare encodings for float_comp.
// The bias only sets the value scale; ordering is bias-independent.
package float_comp_pkg;

  localparam int EXP_W_DEF  = 4;
  localparam int FRAC_W_DEF = 11;
  localparam int BIAS_DEF   = 7;

  localparam logic [2:0] AOPB_GT   = 3'b100;
  localparam logic [2:0] AOPB_EQ   = 3'b010;
  localparam logic [2:0] AOPB_LT   = 3'b001;
  localparam logic [2:0] AOPB_NONE = 3'b000;

  // Unsigned magnitude ordering as a one-hot result.
  function automatic logic [2:0] mag_order(input logic gt, input logic eq);
    if (eq)      mag_order = AOPB_EQ;
    else if (gt) mag_order = AOPB_GT;
    else         mag_order = AOPB_LT;
  endfunction

endpackage

// File: rtl/float_comp_core.sv
// Combinational sign/magnitude compare of two small floats with no inf/NaN.
// Magnitude {exp,frac} is monotonic in value, so subnormal-looking codes need no special case.
module float_comp_core
  import float_comp_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic [EXP_W+FRAC_W:0] a,
  input  logic [EXP_W+FRAC_W:0] b,
  output logic [2:0]            aopb
);

  localparam int MAG_W = EXP_W + FRAC_W;

  logic             sign_a;
  logic             sign_b;
  logic [MAG_W-1:0] mag_a;
  logic [MAG_W-1:0] mag_b;
  logic             mag_gt;
  logic             mag_eq;
  logic             both_zero;

  assign sign_a    = a[MAG_W];
  assign sign_b    = b[MAG_W];
  assign mag_a     = a[MAG_W-1:0];
  assign mag_b     = b[MAG_W-1:0];
  assign mag_gt    = mag_a > mag_b;
  assign mag_eq    = mag_a == mag_b;
  assign both_zero = (mag_a == '0) && (mag_b == '0);

  // Zeroes of either sign are equal; for two negatives the larger magnitude is smaller.
  always_comb begin
    aopb = AOPB_NONE;
    if (both_zero) begin
      aopb = AOPB_EQ;
    end else if (sign_a != sign_b) begin
      aopb = sign_a ? AOPB_LT : AOPB_GT;
    end else if (!sign_a) begin
      aopb = mag_order(mag_gt, mag_eq);
    end else begin
      aopb = mag_order(!mag_gt && !mag_eq, mag_eq);
    end
  end

endmodule

// File: rtl/float_comp.sv
// Registered float comparator: one result per cycle, one cycle after sampling a and b.
// Synchronous reset clears the output to "no result".
module float_comp
  import float_comp_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int BIAS   = BIAS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [EXP_W+FRAC_W:0] a,
  input  logic [EXP_W+FRAC_W:0] b,
  output logic [2:0]            aopb
);

  logic [2:0] cmp;

  float_comp_core #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_core (
    .a    (a),
    .b    (b),
    .aopb (cmp)
  );

  always_ff @(posedge clk) begin
    if (rst) aopb <= AOPB_NONE;
    else     aopb <= cmp;
  end

endmodule

// File: tb/tb_float_comp.sv
// Directed self-checking bench for float_comp with hand-computed expected results.
module tb_float_comp;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  aopb;

  int checks   = 0;
  int failures = 0;

  float_comp dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .aopb (aopb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive operands, let one rising edge capture them, then sample just after it.
  task automatic apply_stimulus(input logic [15:0] va, input logic [15:0] vb, input logic vrst);
    a   = va;
    b   = vb;
    rst = vrst;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [2:0] expected);
    checks++;
    assert (aopb === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: aopb=%b expected=%b", tag, aopb, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    a   = 16'h0000;
    b   = 16'h0000;

    apply_stimulus(16'h4F00, 16'h4900, 1'b1);
    check_output("reset_cycle1", 3'b000);
    apply_stimulus(16'h4F00, 16'h4900, 1'b1);
    check_output("reset_cycle2", 3'b000);
    apply_stimulus(16'h4F00, 16'h4900, 1'b0);
    check_output("first_after_reset_gt", 3'b100);

    apply_stimulus(16'h4700, 16'h47C0, 1'b0);
    check_output("pos_frac_lt", 3'b001);
    apply_stimulus(16'h4700, 16'h4700, 1'b0);
    check_output("pos_identical_eq", 3'b010);
    apply_stimulus(16'h7FFF, 16'h7FFF, 1'b0);
    check_output("max_identical_eq", 3'b010);
    apply_stimulus(16'hFFFF, 16'h7FFF, 1'b0);
    check_output("neg_max_vs_pos_max_lt", 3'b001);
    apply_stimulus(16'hD100, 16'h0000, 1'b0);
    check_output("neg_vs_zero_lt", 3'b001);
    apply_stimulus(16'hCA20, 16'h5040, 1'b0);
    check_output("neg_vs_pos_lt", 3'b001);
    apply_stimulus(16'h8000, 16'h0000, 1'b0);
    check_output("negzero_poszero_eq", 3'b010);
    apply_stimulus(16'h0000, 16'h8000, 1'b0);
    check_output("poszero_negzero_eq", 3'b010);
    apply_stimulus(16'hC900, 16'hCF00, 1'b0);
    check_output("both_neg_gt", 3'b100);
    apply_stimulus(16'hCF00, 16'hC900, 1'b0);
    check_output("both_neg_lt", 3'b001);
    apply_stimulus(16'h5040, 16'hCA20, 1'b0);
    check_output("pos_vs_neg_gt", 3'b100);
    apply_stimulus(16'h0001, 16'h0000, 1'b0);
    check_output("tiny_vs_zero_gt", 3'b100);
    apply_stimulus(16'h8001, 16'h8000, 1'b0);
    check_output("neg_tiny_vs_negzero_lt", 3'b001);
    apply_stimulus(16'h0001, 16'h8001, 1'b0);
    check_output("tiny_sign_diff_gt", 3'b100);
    apply_stimulus(16'h4000, 16'h3FFF, 1'b0);
    check_output("exp_carry_boundary_gt", 3'b100);
    apply_stimulus(16'h8000, 16'h0001, 1'b0);
    check_output("negzero_vs_tiny_lt", 3'b001);
    apply_stimulus(16'h7800, 16'h7FFF, 1'b0);
    check_output("exp15_frac_lt", 3'b001);

    apply_stimulus(16'h4F00, 16'h4900, 1'b1);
    check_output("mid_stream_reset", 3'b000);
    apply_stimulus(16'hC900, 16'hCF00, 1'b0);
    check_output("after_mid_reset_gt", 3'b100);
    apply_stimulus(16'h4700, 16'h47C0, 1'b0);
    check_output("back_to_back_lt", 3'b001);
    apply_stimulus(16'h4700, 16'h47C0, 1'b1);
    check_output("final_reset", 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
